// File: rtl/turn_executor_if.sv
// Command / encoder / motor-control bundle for turn_executor.
// The error signal exists only when TURN_TIMEOUT_EN is defined.
interface turn_executor_if;
    logic               start;
    logic               abort;
    logic signed [31:0] delta_theta_cmd;
    logic               pulse_right;
    logic               pulse_left;
    logic               enable_right;
    logic               enable_left;
    logic               dir_right;
    logic               dir_left;
    logic [31:0]        target_ticks;
    logic               busy;
    logic               done;
`ifdef TURN_TIMEOUT_EN
    logic               error;
`endif

    // Controller / stimulus side
    modport master (
        output start, abort, delta_theta_cmd, pulse_right, pulse_left,
        input  enable_right, enable_left, dir_right, dir_left,
        input  target_ticks, busy, done
`ifdef TURN_TIMEOUT_EN
        , input error
`endif
    );

    // turn_executor side
    modport slave (
        input  start, abort, delta_theta_cmd, pulse_right, pulse_left,
        output enable_right, enable_left, dir_right, dir_left,
        output target_ticks, busy, done
`ifdef TURN_TIMEOUT_EN
        , output error
`endif
    );
endinterface

// File: rtl/turn_executor.sv
// turn_executor: rotates a differential-drive robot in place by a commanded
// angle, driving both wheels in opposite directions until each wheel has
// produced the computed number of encoder ticks.
// Optional feature: define TURN_TIMEOUT_EN to add a no-tick watchdog that
// aborts the turn and pulses bus.error after TIMEOUT_CYCLES silent RUN cycles.
module turn_executor #(
    parameter int unsigned WHEEL_BASE_MM  = 100,
    parameter int unsigned UM_PER_TICK    = 500,
    parameter int unsigned MAX_MRAD       = 31416,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic            clock,
    input  logic            reset,
    turn_executor_if.slave  bus
);
    localparam int unsigned CW = 32;
    localparam int unsigned WW = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cmd_q, cmd_d;
    logic [CW-1:0]   target_q, target_d;
    logic [CW-1:0]   cnt_r_q, cnt_r_d;
    logic [CW-1:0]   cnt_l_q, cnt_l_d;
    logic            dir_r_q, dir_r_d;
    logic            dir_l_q, dir_l_d;
    logic            en_r_q, en_r_d;
    logic            en_l_q, en_l_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            stop_c;

    logic [CW-1:0]   abs_c;
    logic [CW-1:0]   mag_c;
    logic [WW-1:0]   arc_c;
    logic [WW-1:0]   ticks_wide_c;
    logic [CW-1:0]   ticks_c;

`ifdef TURN_TIMEOUT_EN
    logic [CW-1:0]   wd_q, wd_d;
    logic            err_q, err_d;
    logic            timeout_c;
`endif

    // Tick target from the latched command: clamp magnitude, arc length, round to ticks.
    always_comb begin
        abs_c        = cmd_q[CW-1] ? (~cmd_q + CW'(1)) : cmd_q;
        mag_c        = (abs_c > CW'(MAX_MRAD)) ? CW'(MAX_MRAD) : abs_c;
        arc_c        = (WW'(mag_c) * WW'(WHEEL_BASE_MM)) / WW'(2);
        ticks_wide_c = (arc_c + WW'(UM_PER_TICK / 2)) / WW'(UM_PER_TICK);
        ticks_c      = CW'(ticks_wide_c);
    end

`ifdef TURN_TIMEOUT_EN
    // Watchdog: counts RUN cycles with no tick on either wheel.
    always_comb begin
        timeout_c = (state_q == RUN) && !(bus.pulse_right || bus.pulse_left)
                    && (wd_q == CW'(TIMEOUT_CYCLES - 1));
        wd_d      = '0;
        if (state_q == RUN && !(bus.pulse_right || bus.pulse_left))
            wd_d = wd_q + CW'(1);
    end
    assign stop_c = bus.abort || timeout_c;
`else
    assign stop_c = bus.abort;
`endif

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        target_d = target_q;
        cnt_r_d  = cnt_r_q;
        cnt_l_d  = cnt_l_q;
        dir_r_d  = dir_r_q;
        dir_l_d  = dir_l_q;
`ifdef TURN_TIMEOUT_EN
        err_d    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cmd_d   = bus.delta_theta_cmd;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    target_d = ticks_c;
                    dir_r_d  = !cmd_q[CW-1] && (cmd_q != '0);
                    dir_l_d  = cmd_q[CW-1];
                    cnt_r_d  = '0;
                    cnt_l_d  = '0;
                    state_d  = (ticks_c == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (stop_c) begin
                    state_d = IDLE;
`ifdef TURN_TIMEOUT_EN
                    err_d   = timeout_c && !bus.abort;
`endif
                end else if (cnt_r_q >= target_q && cnt_l_q >= target_q) begin
                    state_d = DONE;
                end else begin
                    if (bus.pulse_right && cnt_r_q < target_q)
                        cnt_r_d = cnt_r_q + CW'(1);
                    if (bus.pulse_left && cnt_l_q < target_q)
                        cnt_l_d = cnt_l_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        en_r_d = (state_d == RUN) && (cnt_r_d < target_d);
        en_l_d = (state_d == RUN) && (cnt_l_d < target_d);
        busy_d = (state_d == CALC) || (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            target_q <= '0;
            cnt_r_q  <= '0;
            cnt_l_q  <= '0;
            dir_r_q  <= 1'b0;
            dir_l_q  <= 1'b0;
            en_r_q   <= 1'b0;
            en_l_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            wd_q     <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            target_q <= target_d;
            cnt_r_q  <= cnt_r_d;
            cnt_l_q  <= cnt_l_d;
            dir_r_q  <= dir_r_d;
            dir_l_q  <= dir_l_d;
            en_r_q   <= en_r_d;
            en_l_q   <= en_l_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef TURN_TIMEOUT_EN
            wd_q     <= wd_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus.enable_right = en_r_q;
    assign bus.enable_left  = en_l_q;
    assign bus.dir_right    = dir_r_q;
    assign bus.dir_left     = dir_l_q;
    assign bus.target_ticks = target_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
`ifdef TURN_TIMEOUT_EN
    assign bus.error        = err_q;
`endif

endmodule

// File: tb/tb_turn_executor.sv
// Directed bench for turn_executor: stimulus pushes the expected completion
// record for each turn; a monitor pops and checks it on every done pulse.
module tb_turn_executor;
    logic clock = 1'b0;
    logic reset = 1'b1;

    turn_executor_if bus();

    turn_executor dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] tgt;
        logic        dr;
        logic        dl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding turn.
    always @(negedge clock) begin
        if (!reset && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_target", bus.target_ticks, e.tgt);
                check("done_dir_r",  32'(bus.dir_right), 32'(e.dr));
                check("done_dir_l",  32'(bus.dir_left),  32'(e.dl));
                check("done_enables", 32'({bus.enable_right, bus.enable_left}), 32'd0);
                check("done_busy",   32'(bus.busy), 32'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input logic r, input logic l);
        bus.pulse_right = r;
        bus.pulse_left  = l;
        cyc();
        bus.pulse_right = 1'b0;
        bus.pulse_left  = 1'b0;
    endtask

    // Issue a command; returns #1 after the edge that enters CALC.
    task automatic start_turn(input logic signed [31:0] cmd);
        bus.start           = 1'b1;
        bus.delta_theta_cmd = cmd;
        cyc();
        bus.start           = 1'b0;
        bus.delta_theta_cmd = 32'sd12345;
    endtask

    task automatic push_exp(input logic [31:0] t, input logic dr, input logic dl);
        exp_t e;
        e.tgt = t;
        e.dr  = dr;
        e.dl  = dl;
        exp_q.push_back(e);
    endtask

    initial begin
        bus.start           = 1'b0;
        bus.abort           = 1'b0;
        bus.delta_theta_cmd = '0;
        bus.pulse_right     = 1'b0;
        bus.pulse_left      = 1'b0;
        reset               = 1'b1;
        repeat (3) cyc();
        check("rst_busy",   32'(bus.busy), 32'd0);
        check("rst_done",   32'(bus.done), 32'd0);
        check("rst_en",     32'({bus.enable_right, bus.enable_left}), 32'd0);
        check("rst_dir",    32'({bus.dir_right, bus.dir_left}), 32'd0);
        check("rst_target", bus.target_ticks, 32'd0);
        reset = 1'b0;
        cyc();

        // +1571 mrad: 157 ticks, right forward, left reverse
        push_exp(32'd157, 1'b1, 1'b0);
        start_turn(32'sd1571);
        check("t1_calc_busy", 32'(bus.busy), 32'd1);
        check("t1_calc_en",   32'({bus.enable_right, bus.enable_left}), 32'd0);
        bus.start = 1'b1;   // ignored outside IDLE
        bus.delta_theta_cmd = 32'sd9999;
        cyc();
        bus.start = 1'b0;
        check("t1_target", bus.target_ticks, 32'd157);
        check("t1_dir",    32'({bus.dir_right, bus.dir_left}), 32'b10);
        check("t1_en",     32'({bus.enable_right, bus.enable_left}), 32'b11);
        for (int i = 0; i < 157; i++) pulse(1'b1, 1'b1);
        check("t1_en_low", 32'({bus.enable_right, bus.enable_left}), 32'd0);
        check("t1_busy_run", 32'(bus.busy), 32'd1);
        check("t1_no_done_yet", 32'(bus.done), 32'd0);
        cyc();
        check("t1_done", 32'(bus.done), 32'd1);
        cyc();
        check("t1_done_once", 32'(bus.done), 32'd0);
        check("t1_target_hold", bus.target_ticks, 32'd157);

        // -1000 mrad: 100 ticks, left finishes first
        push_exp(32'd100, 1'b0, 1'b1);
        start_turn(-32'sd1000);
        cyc();
        check("t2_target", bus.target_ticks, 32'd100);
        check("t2_dir",    32'({bus.dir_right, bus.dir_left}), 32'b01);
        for (int i = 0; i < 100; i++) pulse(1'b0, 1'b1);
        check("t2_en_split", 32'({bus.enable_right, bus.enable_left}), 32'b10);
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1);
        check("t2_en_l_stays_low", 32'(bus.enable_left), 32'd0);
        for (int i = 0; i < 99; i++) pulse(1'b1, 1'b0);
        check("t2_en_r_99", 32'(bus.enable_right), 32'd1);
        check("t2_busy_99", 32'(bus.busy), 32'd1);
        pulse(1'b1, 1'b0);
        check("t2_en_r_100", 32'(bus.enable_right), 32'd0);
        cyc();
        check("t2_done", 32'(bus.done), 32'd1);
        cyc();

        // 0 mrad: straight to DONE at start+2
        push_exp(32'd0, 1'b0, 1'b0);
        start_turn(32'sd0);
        check("t3_calc_done", 32'(bus.done), 32'd0);
        cyc();
        check("t3_done", 32'(bus.done), 32'd1);
        check("t3_en",   32'({bus.enable_right, bus.enable_left}), 32'd0);
        cyc();

        // +4 mrad rounds down to 0 ticks; +5 rounds up to 1 tick
        push_exp(32'd0, 1'b1, 1'b0);
        start_turn(32'sd4);
        cyc();
        check("t4_done", 32'(bus.done), 32'd1);
        cyc();
        push_exp(32'd1, 1'b1, 1'b0);
        start_turn(32'sd5);
        cyc();
        check("t5_en", 32'({bus.enable_right, bus.enable_left}), 32'b11);
        pulse(1'b1, 1'b1);
        cyc();
        check("t5_done", 32'(bus.done), 32'd1);
        cyc();

        // -2^31 clamps to 31416 mrad -> 3142 ticks; abort after 50 ticks
        start_turn(32'sh8000_0000);
        cyc();
        check("t6_target", bus.target_ticks, 32'd3142);
        check("t6_dir",    32'({bus.dir_right, bus.dir_left}), 32'b01);
        for (int i = 0; i < 50; i++) pulse(1'b1, 1'b1);
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        check("t6_abort_busy", 32'(bus.busy), 32'd0);
        check("t6_abort_en",   32'({bus.enable_right, bus.enable_left}), 32'd0);
        check("t6_abort_done", 32'(bus.done), 32'd0);
        cyc();
        check("t6_no_late_done", 32'(bus.done), 32'd0);

        // Abort wins over completion in the same cycle
        start_turn(32'sd5);
        cyc();
        pulse(1'b1, 1'b1);
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        check("t7_abort_prio_done", 32'(bus.done), 32'd0);
        check("t7_abort_prio_busy", 32'(bus.busy), 32'd0);
        cyc();

        // Reset mid-RUN (with start and abort also high) clears everything
        start_turn(32'sd1000);
        cyc();
        check("t8_target", bus.target_ticks, 32'd100);
        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b1);
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        cyc();
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("t8_rst_busy",   32'(bus.busy), 32'd0);
        check("t8_rst_en",     32'({bus.enable_right, bus.enable_left}), 32'd0);
        check("t8_rst_dir",    32'({bus.dir_right, bus.dir_left}), 32'd0);
        check("t8_rst_target", bus.target_ticks, 32'd0);
        check("t8_rst_done",   32'(bus.done), 32'd0);
        repeat (3) cyc();
        check("t8_idle_after_rst", 32'(bus.busy), 32'd0);

        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
